// File: rtl/run_control_sequencer.sv
// Run-control sequencer: synchronises the console buttons, arbitrates them, and steps
// the machine through run / single-EP / idle, pulsing ep_pulse on d35 and counting orders.
module run_control_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCKOUT     = 4,
    parameter int CNT_W       = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             resume_btn,
    input  logic             single_ep_btn,
    input  logic             d35,
    input  logic             order_done,
    input  logic             halt_order,
    output logic             ep_pulse,
    output logic             running,
    output logic             stopped,
    output logic             halted,
    output logic [CNT_W-1:0] order_count
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_RUN  = 3'd1;
    localparam logic [2:0] ST_EXEC_RUN  = 3'd2;
    localparam logic [2:0] ST_WAIT_STEP = 3'd3;
    localparam logic [2:0] ST_EXEC_STEP = 3'd4;

    localparam int LK_W = $clog2(LOCKOUT + 1);

    // Bit order doubles as priority order: lower index wins.
    logic [3:0] btn_raw;
    logic [3:0] req_vec;

    assign btn_raw = {single_ep_btn, resume_btn, start_btn, stop_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic [LK_W-1:0]        lock_reg;
            logic                   req_reg;
            logic                   edge_ok;

            // A rising edge only counts once the previous accepted edge has aged out.
            assign edge_ok = sync_reg[SYNC_STAGES-1] & ~prev_reg & (lock_reg == '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                    lock_reg <= '0;
                    req_reg  <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
                    prev_reg <= sync_reg[SYNC_STAGES-1];
                    req_reg  <= edge_ok;
                    if (edge_ok) begin
                        lock_reg <= LK_W'(LOCKOUT);
                    end else if (lock_reg != '0) begin
                        lock_reg <= lock_reg - 1'b1;
                    end
                end
            end

            assign req_vec[gi] = req_reg;
        end
    endgenerate

    logic win_stop, win_start, win_resume, win_single;

    assign win_stop   = req_vec[0];
    assign win_start  = req_vec[1] & ~req_vec[0];
    assign win_resume = req_vec[2] & ~|req_vec[1:0];
    assign win_single = req_vec[3] & ~|req_vec[2:0];

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             halted_reg, halted_next;
    logic             pend_reg, pend_next;
    logic             running_reg, stopped_reg;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        halted_next = halted_reg;
        pend_next   = pend_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_start) begin
                    count_next  = '0;
                    halted_next = 1'b0;
                    state_next  = ST_WAIT_RUN;
                end else if (win_resume) begin
                    halted_next = 1'b0;
                    state_next  = ST_WAIT_RUN;
                end else if (win_single) begin
                    halted_next = 1'b0;
                    state_next  = ST_WAIT_STEP;
                end
            end
            ST_WAIT_RUN: begin
                if (win_stop) begin
                    state_next = ST_IDLE;
                end else if (d35) begin
                    state_next = ST_EXEC_RUN;
                end
            end
            ST_EXEC_RUN: begin
                // A stop during an order is remembered so the order still completes.
                if (win_stop) begin
                    pend_next = 1'b1;
                end
                if (order_done) begin
                    count_next = count_reg + CNT_W'(1);
                    if (halt_order) begin
                        halted_next = 1'b1;
                        state_next  = ST_IDLE;
                    end else if (pend_reg | win_stop) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_RUN;
                    end
                end
            end
            ST_WAIT_STEP: begin
                if (win_stop) begin
                    state_next = ST_IDLE;
                end else if (d35) begin
                    state_next = ST_EXEC_STEP;
                end
            end
            ST_EXEC_STEP: begin
                if (order_done) begin
                    count_next  = count_reg + CNT_W'(1);
                    halted_next = halt_order;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (state_next == ST_IDLE) begin
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            halted_reg  <= 1'b0;
            pend_reg    <= 1'b0;
            running_reg <= 1'b0;
            stopped_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            halted_reg  <= halted_next;
            pend_reg    <= pend_next;
            running_reg <= (state_next == ST_WAIT_RUN) || (state_next == ST_EXEC_RUN);
            stopped_reg <= (state_next == ST_IDLE);
        end
    end

    // A stop arriving on the d35 cycle cancels the pulse along with the wait.
    assign ep_pulse    = d35 & ~win_stop &
                         ((state_reg == ST_WAIT_RUN) || (state_reg == ST_WAIT_STEP));
    assign running     = running_reg;
    assign stopped     = stopped_reg;
    assign halted      = halted_reg;
    assign order_count = count_reg;

endmodule
